// File: rtl/id_issue_buffer.sv
// Fetch-to-decode issue buffer: a circular FIFO of {pc, instr, exc} entries with load-use interlock.
// Optional combinational bypass of an empty buffer is enabled by defining ID_ISSUE_BYPASS_EN.
module id_issue_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EXC_W = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_instr,
  input  logic [EXC_W-1:0]           if_exc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic [EXC_W-1:0]           id_exc,
  input  logic                       id_rs_read,
  input  logic                       id_rt_read,
  input  logic [4:0]                 exe_rt,
  input  logic                       exe_readmem,
  output logic                       hazard_stall,
  output logic                       exe_bubble,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem   [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty, full, bypass, consume, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign if_ready = !full;

`ifdef ID_ISSUE_BYPASS_EN
  assign bypass = empty && if_valid;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = !empty || bypass;
  assign id_pc    = bypass ? if_pc    : pc_mem[rd_q];
  assign id_instr = bypass ? if_instr : instr_mem[rd_q];
  assign id_exc   = bypass ? if_exc   : exc_mem[rd_q];

  assign hazard_stall = id_valid && exe_readmem && (exe_rt != 5'd0) &&
                        ((id_rs_read && (exe_rt == id_instr[25:21])) ||
                         (id_rt_read && (exe_rt == id_instr[20:16])));
  assign exe_bubble   = hazard_stall;

  assign consume = id_valid && id_ready && !hazard_stall && !flush;
  // A bypassed entry that decode takes this cycle never touches storage.
  assign pop  = consume && !bypass;
  assign push = if_valid && if_ready && !flush && !(bypass && consume);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= if_pc;
      instr_mem[wr_q] <= if_instr;
      exc_mem[wr_q]   <= if_exc;
    end
  end

  assign count = count_q;

endmodule
